// File: rtl/run_detect_pkg.sv
// run_detect_pkg: shared types and constants for the run-length detector.
package run_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIT   = 2'd2,
    HOLD  = 2'd3
  } run_state_t;

  localparam int MODE_ONCE  = 0;
  localparam int MODE_REARM = 1;

endpackage

// File: rtl/run_detect_ch.sv
// run_detect_ch: one channel of the run-length detector.
// Optional hit counter is built only when RUN_DETECT_HITCNT_EN is defined.
//
//   state | meaning
//   IDLE  | no run in progress (last sample 0, or just out of reset)
//   COUNT | run in progress, fewer than RUN_LEN ones seen
//   HIT   | run just reached RUN_LEN ones; q is high
//   HOLD  | run already reported, waiting for a 0 (one-pulse mode only)
module run_detect_ch
  import run_detect_pkg::*;
#(
  parameter int RUN_LEN = 1,
  parameter int MODE    = MODE_ONCE,
  parameter int HCW     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i,
  output logic           q
`ifdef RUN_DETECT_HITCNT_EN
  ,
  input  logic           clr,
  output logic [HCW-1:0] hit_cnt
`endif
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(RUN_LEN);

  run_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  // State and run counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: any 0 ends the run; ones advance the count.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, COUNT: begin
          cnt_n   = cnt_inc;
          state_n = (cnt_inc == LEN_C) ? HIT : COUNT;
        end
        HIT: begin
          if (MODE == MODE_REARM) begin
            // The current 1 is the first sample of the next run.
            cnt_n   = CW'(1);
            state_n = (RUN_LEN == 1) ? HIT : COUNT;
          end else begin
            state_n = HOLD;
          end
        end
        HOLD:    state_n = HOLD;
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Moore output: pulse while in HIT.
  always_comb begin
    q = (state == HIT);
  end

`ifdef RUN_DETECT_HITCNT_EN
  logic [HCW-1:0] hcnt;

  // Saturating count of HIT entries; clear takes priority over a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
    end else if (clr) begin
      hcnt <= '0;
    end else if (state_n == HIT && hcnt != {HCW{1'b1}}) begin
      hcnt <= hcnt + HCW'(1);
    end
  end

  assign hit_cnt = hcnt;
`endif

endmodule

// File: rtl/run_detect.sv
// run_detect: NCH independent run-length detectors.
// Define RUN_DETECT_HITCNT_EN to add clr and per-channel hit_cnt.
module run_detect
  import run_detect_pkg::*;
#(
  parameter int NCH     = 1,
  parameter int RUN_LEN = 1,
  parameter int MODE    = MODE_ONCE,
  parameter int HCW     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     i,
  output logic [NCH-1:0]     q
`ifdef RUN_DETECT_HITCNT_EN
  ,
  input  logic               clr,
  output logic [NCH*HCW-1:0] hit_cnt
`endif
);

  if (NCH < 1 || RUN_LEN < 1 || MODE < 0 || MODE > 1) begin : g_bad_param
    $error("run_detect: illegal parameters NCH=%0d RUN_LEN=%0d MODE=%0d", NCH, RUN_LEN, MODE);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    run_detect_ch #(
      .RUN_LEN (RUN_LEN),
      .MODE    (MODE),
      .HCW     (HCW)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .i       (i[c]),
      .q       (q[c])
`ifdef RUN_DETECT_HITCNT_EN
      ,
      .clr     (clr),
      .hit_cnt (hit_cnt[c*HCW +: HCW])
`endif
    );
  end

endmodule
